// File: rtl/mvu_pe_mac_if.sv
// Beat input stream and dot-product output stream of one PE MAC stage.
interface mvu_pe_mac_if #(
    parameter int unsigned SIMD = 2,
    parameter int unsigned TW   = 1,
    parameter int unsigned TI   = 4,
    parameter int unsigned TA   = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [SIMD*TW-1:0]   in_wgt;
    logic [SIMD*TI-1:0]   in_act;
    logic                 out_valid;
    logic                 out_ready;
    logic [TA-1:0]        out_acc;

    // Producer of beats / consumer of results.
    modport master (
        output in_valid, in_wgt, in_act, out_ready,
        input  in_ready, out_valid, out_acc
    );

    // The MAC stage itself.
    modport slave (
        input  in_valid, in_wgt, in_act, out_ready,
        output in_ready, out_valid, out_acc
    );
endinterface

// File: rtl/mvu_pe_mac.sv
// Per-PE multiply-accumulate: SIMD lane products, adder-tree reduction,
// accumulation over SF beats, one TA-bit dot product per output channel.
module mvu_pe_mac #(
    parameter int unsigned SIMD       = 2,
    parameter int unsigned TW         = 1,
    parameter int unsigned TI         = 4,
    parameter int unsigned SIGNED_ACT = 1,
    parameter int unsigned TA         = 16,
    parameter int unsigned SF         = 4
) (
    input  logic          clock,
    input  logic          reset,
    mvu_pe_mac_if.slave   io_bus
);
    localparam int unsigned PW  = TW + TI + 1;
    localparam int unsigned SW  = PW + $clog2(SIMD);
    localparam int unsigned FCW = (SF > 1) ? $clog2(SF) : 1;

    logic                  w_en;
    logic                  w_accept;
    logic                  w_last;
    logic signed [PW-1:0]  w_prod [SIMD];
    logic signed [SW-1:0]  w_sum;
    logic [TA-1:0]         w_next;

    logic [FCW-1:0]        r_fc;
    logic                  r_v1;
    logic                  r_l1;
    logic signed [PW-1:0]  r_p [SIMD];
    logic                  r_v2;
    logic                  r_l2;
    logic signed [SW-1:0]  r_s;
    logic [TA-1:0]         r_acc;
    logic                  r_first;
    logic                  r_out_valid;
    logic [TA-1:0]         r_out_acc;

    // Whole pipeline advances only when the output slot can take a result.
    assign w_en     = !r_out_valid || io_bus.out_ready;
    assign w_accept = io_bus.in_valid && w_en;
    assign w_last   = (r_fc == FCW'(SF - 1));

    assign io_bus.in_ready  = w_en;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_acc   = r_out_acc;

    // Per-lane product; TW==1 treats the weight bit as +1/-1.
    for (genvar g = 0; g < SIMD; g++) begin : g_lane
        logic [TI-1:0]        w_a;
        logic [TW-1:0]        w_w;
        logic signed [PW-1:0] w_a_ext;

        assign w_a     = io_bus.in_act[g*TI +: TI];
        assign w_w     = io_bus.in_wgt[g*TW +: TW];
        assign w_a_ext = (SIGNED_ACT != 0) ? PW'($signed(w_a)) : PW'($unsigned(w_a));

        if (TW == 1) begin : g_bip
            assign w_prod[g] = w_w[0] ? w_a_ext : -w_a_ext;
        end else begin : g_mul
            logic signed [PW-1:0] w_w_ext;
            assign w_w_ext   = PW'($signed(w_w));
            assign w_prod[g] = w_w_ext * w_a_ext;
        end
    end

    // Reduce registered lane products into one beat sum.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < SIMD; i++) begin
            w_sum = w_sum + SW'(r_p[i]);
        end
    end

    // First beat of a fold starts from zero rather than the stored partial.
    assign w_next = (r_first ? '0 : r_acc) + TA'(r_s);

    // Fold counter: counts accepted beats only, wraps after SF-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fc <= '0;
        end else if (w_accept) begin
            r_fc <= w_last ? '0 : r_fc + FCW'(1);
        end
    end

    // Stage 1: lane products with valid/last tags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_v1 <= 1'b0;
            r_l1 <= 1'b0;
            for (int i = 0; i < SIMD; i++) r_p[i] <= '0;
        end else if (w_en) begin
            r_v1 <= w_accept;
            r_l1 <= w_accept && w_last;
            for (int i = 0; i < SIMD; i++) r_p[i] <= w_prod[i];
        end
    end

    // Stage 2: reduced beat sum.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_v2 <= 1'b0;
            r_l2 <= 1'b0;
            r_s  <= '0;
        end else if (w_en) begin
            r_v2 <= r_v1;
            r_l2 <= r_l1;
            r_s  <= w_sum;
        end
    end

    // Stage 3: accumulate, hand off completed folds to the output register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_first     <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
        end else begin
            if (w_en && r_v2) begin
                if (r_l2) begin
                    r_acc   <= '0;
                    r_first <= 1'b1;
                end else begin
                    r_acc   <= w_next;
                    r_first <= 1'b0;
                end
            end
            if (w_en && r_v2 && r_l2) begin
                r_out_acc   <= w_next;
                r_out_valid <= 1'b1;
            end else if (io_bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule
